// File: rtl/pc_fetch_sequencer.sv
// Program counter owner and single-outstanding instruction fetch sequencer.
// Optional misaligned-redirect trap enabled by defining PCSEQ_MISALIGN_TRAP_EN.
module pc_fetch_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] TRAP_VEC = 32'h0000_0100,
  parameter int unsigned PC_STEP  = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        jump_valid,
  input  logic [31:0] jump_addr,
  input  logic        branch_taken,
  input  logic [31:0] branch_addr,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic [1:0]  pc_src,
  output logic [31:0] pc,
  output logic        trap_valid
);

  typedef enum logic [1:0] {BOOT, FETCH, WAIT, DISCARD} state_t;

  state_t      state;
  state_t      state_next;
  logic        redirect;
  logic [31:0] redirect_addr;
  logic [31:0] redirect_pc;
  logic        trap_hit;
  logic        capture;
  logic        skid_full;
  logic [31:0] skid_instr;
  logic [31:0] skid_pc;

  assign redirect      = jump_valid | branch_taken;
  assign redirect_addr = jump_valid ? jump_addr : branch_addr;

`ifdef PCSEQ_MISALIGN_TRAP_EN
  assign trap_hit = redirect && (redirect_addr[1:0] != 2'b00);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) trap_valid <= 1'b0;
    else       trap_valid <= trap_hit;
  end
`else
  assign trap_hit   = 1'b0;
  assign trap_valid = 1'b0;
`endif

  assign redirect_pc = trap_hit ? TRAP_VEC : redirect_addr;
  assign imem_addr   = pc;
  // A returning word is kept only if no redirect squashes it in the same cycle.
  assign capture     = (state == WAIT) && imem_rvalid && !redirect;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= BOOT;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      BOOT:    state_next = FETCH;
      FETCH:   if (imem_req && imem_gnt) state_next = WAIT;
      WAIT: begin
        if (imem_rvalid)   state_next = FETCH;
        else if (redirect) state_next = DISCARD;
      end
      DISCARD: if (imem_rvalid) state_next = FETCH;
      default: state_next = BOOT;
    endcase
  end

  always_comb begin
    imem_req = 1'b0;
    pc_src   = 2'b00;
    if ((state == FETCH) && !stall && !redirect && !skid_full) imem_req = 1'b1;
    if (jump_valid && !trap_hit)        pc_src = 2'b01;
    else if (branch_taken && !trap_hit) pc_src = 2'b10;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                          pc <= RESET_PC;
    else if (redirect)                  pc <= redirect_pc;
    else if ((state == WAIT) && imem_rvalid) pc <= pc + PC_STEP;
  end

  // Output stage with a one-entry skid that absorbs a word returning under stall.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instr_valid <= 1'b0;
      instr       <= 32'h0;
      instr_pc    <= 32'h0;
      skid_full   <= 1'b0;
      skid_instr  <= 32'h0;
      skid_pc     <= 32'h0;
    end else if (redirect) begin
      instr_valid <= 1'b0;
      skid_full   <= 1'b0;
    end else if (stall) begin
      if (capture) begin
        skid_full  <= 1'b1;
        skid_instr <= imem_rdata;
        skid_pc    <= pc;
      end
    end else if (skid_full) begin
      instr_valid <= 1'b1;
      instr       <= skid_instr;
      instr_pc    <= skid_pc;
      skid_full   <= 1'b0;
    end else begin
      instr_valid <= capture;
      if (capture) begin
        instr    <= imem_rdata;
        instr_pc <= pc;
      end
    end
  end

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Self-checking bench for pc_fetch_sequencer: directed scenarios then randomized traffic
// against a program-flow model (delivered and fetched PCs follow +4 or the latest redirect).
module tb_pc_fetch_sequencer;

`ifdef PCSEQ_MISALIGN_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] TRAP_VEC = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        jump_valid = 1'b0;
  logic [31:0] jump_addr = 32'h0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_addr = 32'h0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [1:0]  pc_src;
  logic [31:0] pc;
  logic        trap_valid;

  int checks = 0;
  int failures = 0;
  int deliveries = 0;

  // memory model and scoreboard state
  logic        pending = 1'b0;
  logic [31:0] pend_addr = 32'h0;
  int          lat_cnt = 0;
  int          lat_min = 1;
  int          lat_max = 1;
  int          gnt_pct = 100;
  logic [31:0] exp_next = RESET_PC;
  logic [31:0] exp_fetch = RESET_PC;
  logic        exp_trap = 1'b0;

  logic        s_req;
  logic [31:0] s_addr;
  logic [1:0]  s_src;

  pc_fetch_sequencer dut (
    .clk(clk), .reset(reset), .stall(stall),
    .jump_valid(jump_valid), .jump_addr(jump_addr),
    .branch_taken(branch_taken), .branch_addr(branch_addr),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
    .pc_src(pc_src), .pc(pc), .trap_valid(trap_valid)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h5A5A_3C3C;
  endfunction

  function automatic logic is_trap(input logic jv, input logic [31:0] ja,
                                   input logic bt, input logic [31:0] ba);
    logic [31:0] t;
    t = jv ? ja : ba;
    return TRAP_EN && (jv || bt) && (t[1:0] != 2'b00);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  // One clock cycle: called at a falling edge, returns at the next falling edge.
  task automatic step(input logic s, input logic jv, input logic [31:0] ja,
                      input logic bt, input logic [31:0] ba);
    logic        trap;
    logic [31:0] tgt;
    logic [1:0]  exp_src;
    if (pending && lat_cnt == 0) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mem_word(pend_addr);
      pending     = 1'b0;
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
      if (pending) lat_cnt--;
    end
    stall = s; jump_valid = jv; jump_addr = ja; branch_taken = bt; branch_addr = ba;
    imem_gnt = 1'b0;
    #1;
    s_req = imem_req; s_addr = imem_addr; s_src = pc_src;
    trap = is_trap(jv, ja, bt, ba);
    tgt  = trap ? TRAP_VEC : (jv ? ja : ba);
    exp_src = trap ? 2'b00 : (jv ? 2'b01 : (bt ? 2'b10 : 2'b00));
    if (!reset) begin
      check("pc_src", 32'(pc_src), 32'(exp_src));
      check("trap_valid", 32'(trap_valid), 32'(exp_trap));
      exp_trap = trap;
      if (s || jv || bt) check("req_blocked", 32'(imem_req), 32'd0);
      if (imem_req) check("fetch_addr", imem_addr, exp_fetch);
      if (imem_req && !pending && ($urandom_range(99, 0) < gnt_pct)) begin
        imem_gnt  = 1'b1;
        pending   = 1'b1;
        pend_addr = imem_addr;
        lat_cnt   = $urandom_range(lat_max, lat_min) - 1;
        exp_fetch = exp_fetch + 32'd4;
      end
      if (instr_valid && !s) begin
        check("instr_pc", instr_pc, exp_next);
        check("instr", instr, mem_word(exp_next));
        exp_next = exp_next + 32'd4;
        deliveries++;
      end
      if (jv || bt) begin
        exp_next  = tgt;
        exp_fetch = tgt;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    int rand_start;
    int r;
    logic [31:0] ta, tb;
    repeat (2) @(negedge clk);
    check("rst_req", 32'(imem_req), 32'd0);
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_instr", instr, 32'd0);
    check("rst_instr_pc", instr_pc, 32'd0);
    check("rst_pc_src", 32'(pc_src), 32'd0);
    check("rst_pc", pc, RESET_PC);
    check("rst_trap", 32'(trap_valid), 32'd0);
    reset = 1'b0;

    // sequential fetch with a 1-cycle memory
    for (int k = 0; k < 7; k++) begin
      step(0, 0, 0, 0, 0);
      if (k % 2 == 1) begin
        check("seq_req", 32'(s_req), 32'd1);
        check("seq_addr", s_addr, 32'((k - 1) * 2));
      end else begin
        check("seq_req_idle", 32'(s_req), 32'd0);
      end
      if (k >= 2) begin
        check("seq_valid", 32'(instr_valid), 32'(k % 2 == 0));
        if (k % 2 == 0) check("seq_instr_pc", instr_pc, 32'((k - 2) * 2));
      end
    end

    // jump while waiting for data: in-flight word dropped
    step(0, 0, 0, 0, 0);
    check("jmp_pre_addr", s_addr, 32'h0000_000C);
    step(0, 1, 32'h40, 0, 0);
    check("jmp_pc_src", 32'(s_src), 32'd1);
    check("jmp_drop", 32'(instr_valid), 32'd0);
    step(0, 0, 0, 0, 0);
    check("jmp_req", 32'(s_req), 32'd1);
    check("jmp_addr", s_addr, 32'h40);
    step(0, 0, 0, 0, 0);
    check("jmp_deliver", instr_pc, 32'h40);

    // jump and branch together: jump wins
    step(0, 1, 32'h80, 1, 32'h200);
    check("pri_pc_src", 32'(s_src), 32'd1);
    check("pri_req", 32'(s_req), 32'd0);
    step(0, 0, 0, 0, 0);
    check("pri_addr", s_addr, 32'h80);
    step(0, 0, 0, 0, 0);
    check("pri_deliver", instr_pc, 32'h80);

    // stall with a fetch outstanding
    lat_min = 3; lat_max = 3;
    step(0, 0, 0, 0, 0);
    check("stall_pre_addr", s_addr, 32'h84);
    for (int k = 0; k < 5; k++) begin
      step(1, 0, 0, 0, 0);
      check("stall_req", 32'(s_req), 32'd0);
      check("stall_valid_held", 32'(instr_valid), 32'd0);
      check("stall_pc_held", instr_pc, 32'h80);
    end
    lat_min = 1; lat_max = 1;
    step(0, 0, 0, 0, 0);
    check("skid_req", 32'(s_req), 32'd0);
    check("skid_valid", 32'(instr_valid), 32'd1);
    check("skid_pc", instr_pc, 32'h84);
    step(0, 0, 0, 0, 0);
    check("skid_next_addr", s_addr, 32'h88);

    // wraparound of the sequential advance
    step(0, 1, 32'hFFFF_FFFC, 0, 0);
    step(0, 0, 0, 0, 0);
    check("wrap_top_addr", s_addr, 32'hFFFF_FFFC);
    step(0, 0, 0, 0, 0);
    check("wrap_pc", pc, 32'h0);
    check("wrap_instr_pc", instr_pc, 32'hFFFF_FFFC);
    step(0, 0, 0, 0, 0);
    check("wrap_addr", s_addr, 32'h0);

    // misaligned branch target
    step(0, 0, 0, 1, 32'h102);
    check("mis_pc_src", 32'(s_src), TRAP_EN ? 32'd0 : 32'd2);
    check("mis_trap", 32'(trap_valid), 32'(TRAP_EN));
    step(0, 0, 0, 0, 0);
    check("mis_addr", s_addr, TRAP_EN ? 32'h100 : 32'h102);
    step(0, 0, 0, 0, 0);

    // reset in the middle of a transaction; the late word is ignored
    lat_min = 3; lat_max = 3;
    step(0, 0, 0, 0, 0);
    reset = 1'b1;
    exp_next = RESET_PC; exp_fetch = RESET_PC; exp_trap = 1'b0;
    step(0, 0, 0, 0, 0);
    check("mid_rst_pc", pc, RESET_PC);
    reset = 1'b0;
    step(0, 0, 0, 0, 0);
    check("mid_boot_valid", 32'(instr_valid), 32'd0);
    step(0, 0, 0, 0, 0);
    check("mid_late_valid", 32'(instr_valid), 32'd0);
    check("mid_first_addr", s_addr, RESET_PC);
    for (int k = 0; k < 12 && !instr_valid; k++) step(0, 0, 0, 0, 0);
    check("mid_deliver_valid", 32'(instr_valid), 32'd1);
    check("mid_deliver_pc", instr_pc, RESET_PC);

    // randomized traffic
    lat_min = 1; lat_max = 3; gnt_pct = 70;
    rand_start = deliveries;
    for (int n = 0; n < 3000; n++) begin
      r  = $urandom_range(99, 0);
      ta = ($urandom_range(9, 0) == 0) ? 32'hFFFF_FFF8 : ($urandom_range(1023, 0) << 2);
      tb = $urandom_range(1023, 0) << 2;
      step($urandom_range(99, 0) < 30, r < 5, ta, (r >= 3) && (r < 9), tb);
    end
    check("liveness", 32'((deliveries - rand_start) > 100), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
